// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid stage.
//   pipe_state_e  : stage fill state; the encoded value equals the number of
//                   entries held (0, 1 or 2), so it doubles as occupancy.
//   DEFAULT_WIDTH : default payload width for stage and data registers.
package pipe_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register used for the main and skid entries of pipe_skid_stage.
// Ports:
//   clk   in  1      clock, posedge
//   rst   in  1      asynchronous active-high reset, loads RESET_VAL
//   clr   in  1      synchronous clear, loads RESET_VAL; wins over load
//   load  in  1      capture d on the next posedge
//   d     in  WIDTH  next value
//   q     out WIDTH  registered value
module pipe_data_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (clr) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a valid/ready handshake and a 2-entry skid
// buffer. in_ready comes from a flop, so there is no combinational path from
// out_ready back to in_ready. Supports synchronous flush and a configurable
// reset/clear value.
//
// Handshake: a word moves across a port on a posedge where both valid and
// ready are high (in_valid & in_ready upstream, out_valid & out_ready
// downstream). A valid source keeps valid and data stable until accepted.
// A cycle with flush high voids both transfers of that cycle.
//
// Ports:
//   clk        in  1      clock, posedge
//   rst        in  1      asynchronous active-high reset
//   flush      in  1      synchronous flush, discards all held entries
//   in_valid   in  1      upstream offers in_data
//   in_ready   out 1      stage can accept (registered)
//   in_data    in  WIDTH  upstream payload
//   out_valid  out 1      out_data holds a valid entry
//   out_ready  in  1      downstream accepts out_data
//   out_data   out WIDTH  payload, straight from the main register
//   occupancy  out 2      entries held (0..2); this is the FSM state
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH          = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL      = '0,
  parameter bit               CLEAR_ON_FLUSH = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  pipe_state_e      state_q;
  pipe_state_e      state_d;
  logic             in_ready_q;
  logic             in_acc;
  logic             out_acc;
  logic             main_load;
  logic             main_from_skid;
  logic             skid_load;
  logic             data_clr;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign occupancy = state_q;
  assign out_data  = main_q;

  assign in_acc  = in_valid & in_ready_q;
  assign out_acc = out_valid & out_ready;

  // Next state and register load strobes. Flush is applied last so it
  // overrides every handshake decision made above it.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_acc) begin
          main_load = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (in_acc && out_acc) begin
          main_load = 1'b1;
        end else if (in_acc) begin
          // Downstream stalled: park the younger word in the skid register.
          skid_load = 1'b1;
          state_d   = TWO;
        end else if (out_acc) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only the drain side can move.
        if (out_acc) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d        = EMPTY;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
    end
  end

  assign main_d   = main_from_skid ? skid_q : in_data;
  assign data_clr = flush & CLEAR_ON_FLUSH;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // in_ready tracks the next state so it is valid in the same cycle as it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= (state_d != TWO);
    end
  end

  pipe_data_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk  (clk),
    .rst  (rst),
    .clr  (data_clr),
    .load (main_load),
    .d    (main_d),
    .q    (main_q)
  );

  pipe_data_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .clr  (data_clr),
    .load (skid_load),
    .d    (in_data),
    .q    (skid_q)
  );

endmodule
